// File: rtl/axi_sts_snapshot_register.sv
// rtl/axi_sts_snapshot_register.sv - AXI4-Lite read-only status bank with snapshot shadow (optional feature macro: AXI_STS_SNAPSHOT_EN)
module axi_sts_snapshot_register #(
    parameter int STS_DATA_WIDTH = 1024,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [STS_DATA_WIDTH-1:0] sts_data,

    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,

    input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,

    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,

    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,

    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);
    localparam int STS_SIZE = STS_DATA_WIDTH / AXI_DATA_WIDTH;
    localparam int IDX_W    = AXI_ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_W:0] STS_SIZE_L = (IDX_W + 1)'(STS_SIZE);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Read path state: output register plus one-entry skid (index only;
    // data is sampled when the output register loads).
    logic                      r_rvalid;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                r_rresp;
    logic                      r_skid_valid;
    logic [IDX_W-1:0]          r_skid_idx;

    // Write path state: independent AW/W latches and the response flop.
    logic                      r_aw_latched;
    logic                      r_w_latched;
    logic                      r_bvalid;
    logic [1:0]                r_bresp;

    logic                      w_ar_hs;
    logic                      w_out_free;
    logic                      w_load;
    logic                      w_load_oor;
    logic                      w_load_snap;
    logic [IDX_W-1:0]          w_ar_idx;
    logic [IDX_W-1:0]          w_load_idx;
    logic [AXI_DATA_WIDTH-1:0] w_live_word;
    logic [AXI_DATA_WIDTH-1:0] w_load_data;
    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_b_hs;
    logic                      w_aw_have;
    logic                      w_w_have;
    logic                      w_unused_ok;

    // Address bits below the word boundary and all write payload are ignored.
    assign w_unused_ok = ^{s_axi_awaddr, s_axi_wdata, s_axi_araddr[ADDR_LSB-1:0]};

    // Skid full means two reads are already held, so stop accepting.
    assign s_axi_arready = ~r_skid_valid;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    assign w_ar_idx   = s_axi_araddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign w_ar_hs    = s_axi_arvalid & s_axi_arready;
    assign w_out_free = ~r_rvalid | s_axi_rready;

    // The skid always has priority: it holds the older request.
    assign w_load      = w_out_free & (r_skid_valid | w_ar_hs);
    assign w_load_idx  = r_skid_valid ? r_skid_idx : w_ar_idx;
    assign w_load_oor  = ({1'b0, w_load_idx} >= STS_SIZE_L);
    assign w_load_snap = w_load & ~w_load_oor & (w_load_idx == '0);

    // Select the live status word addressed by the loading request.
    always_comb begin
        w_live_word = '0;
        for (int k = 0; k < STS_SIZE; k++) begin
            if (w_load_idx == IDX_W'(k)) begin
                w_live_word = sts_data[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
        end
    end

`ifdef AXI_STS_SNAPSHOT_EN
    logic [STS_DATA_WIDTH-1:0] r_shadow;
    logic [AXI_DATA_WIDTH-1:0] w_shadow_word;

    // Select the shadow word addressed by the loading request.
    always_comb begin
        w_shadow_word = '0;
        for (int k = 0; k < STS_SIZE; k++) begin
            if (w_load_idx == IDX_W'(k)) begin
                w_shadow_word = r_shadow[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
        end
    end

    // Word 0 reads live and freezes the whole vector for the following words.
    always_comb begin
        w_load_data = (w_load_idx == '0) ? w_live_word : w_shadow_word;
        if (w_load_oor) begin
            w_load_data = '0;
        end
    end

    // Capture the full status vector on the edge that serves an idx-0 read.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_shadow <= '0;
        end else if (w_load_snap) begin
            r_shadow <= sts_data;
        end
    end
`else
    logic w_unused_snap;
    assign w_unused_snap = w_load_snap;

    // Without the shadow every word is read live at the output-load edge.
    always_comb begin
        w_load_data = w_live_word;
        if (w_load_oor) begin
            w_load_data = '0;
        end
    end
`endif

    // Read pipeline: load the output register when free, else park in the skid.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_rresp      <= RESP_OKAY;
            r_skid_valid <= 1'b0;
            r_skid_idx   <= '0;
        end else if (w_out_free) begin
            r_rvalid     <= w_load;
            r_skid_valid <= 1'b0;
            if (w_load) begin
                r_rdata <= w_load_data;
                r_rresp <= w_load_oor ? RESP_SLVERR : RESP_OKAY;
            end
        end else if (w_ar_hs) begin
            r_skid_valid <= 1'b1;
            r_skid_idx   <= w_ar_idx;
        end
    end

    assign s_axi_awready = ~r_aw_latched;
    assign s_axi_wready  = ~r_w_latched;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;

    assign w_aw_hs   = s_axi_awvalid & s_axi_awready;
    assign w_w_hs    = s_axi_wvalid & s_axi_wready;
    assign w_b_hs    = r_bvalid & s_axi_bready;
    assign w_aw_have = r_aw_latched | w_aw_hs;
    assign w_w_have  = r_w_latched | w_w_hs;

    // Write channel: latch AW and W independently, answer SLVERR once both are in.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_aw_latched <= 1'b0;
            r_w_latched  <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
        end else if (w_b_hs) begin
            r_aw_latched <= 1'b0;
            r_w_latched  <= 1'b0;
            r_bvalid     <= 1'b0;
        end else begin
            r_aw_latched <= w_aw_have;
            r_w_latched  <= w_w_have;
            if (w_aw_have && w_w_have && !r_bvalid) begin
                r_bvalid <= 1'b1;
                r_bresp  <= RESP_SLVERR;
            end
        end
    end

endmodule

// File: doc/axi_sts_snapshot_register.md
# axi_sts_snapshot_register

AXI4-Lite read-only status register bank exposing a wide `sts_data` vector to the PS as `AXI_DATA_WIDTH` words. It adds the following:
- Coherent multi-word reads via a snapshot shadow.
- A one-entry read skid buffer for full-throughput, back-pressure-safe reads.
- SLVERR for out-of-range reads.
- A fully handshaken write channel that rejects all writes.

It sits between the AXI interconnect and PL status sources (counters, timestamps, FIFO levels).

## Interface
- `STS_DATA_WIDTH`, 1024: status vector width; must be a multiple of `AXI_DATA_WIDTH`.
- `AXI_DATA_WIDTH`, 32: AXI data width; 32 or 64.
- `AXI_ADDR_WIDTH`, 16: AXI address width.
- Derived values:
  - `ADDR_LSB` = log2(`AXI_DATA_WIDTH`/8).
  - `STS_SIZE` = `STS_DATA_WIDTH`/`AXI_DATA_WIDTH`; need not be a power of two.

- `aclk` in 1: single clock; all logic on its rising edge.
- `aresetn` in 1: reset is asynchronous and active-low.
- `sts_data` in `STS_DATA_WIDTH`: live status; word k = bits [k*`AXI_DATA_WIDTH` +: `AXI_DATA_WIDTH`].
- Write address: `s_axi_awaddr` in `AXI_ADDR_WIDTH`, `s_axi_awvalid` in 1, `s_axi_awready` out 1.
- Write data: `s_axi_wdata` in `AXI_DATA_WIDTH`, `s_axi_wvalid` in 1, `s_axi_wready` out 1.
- Write response: `s_axi_bresp` out 2, `s_axi_bvalid` out 1, `s_axi_bready` in 1.
- Read address: `s_axi_araddr` in `AXI_ADDR_WIDTH`, `s_axi_arvalid` in 1, `s_axi_arready` out 1.
- Read data: `s_axi_rdata` out `AXI_DATA_WIDTH`, `s_axi_rresp` out 2, `s_axi_rvalid` out 1, `s_axi_rready` in 1.

## Operation
- Word index: idx = `araddr`[`AXI_ADDR_WIDTH`-1:`ADDR_LSB`]. Low `ADDR_LSB` bits are ignored.
- Out-of-range read (idx >= `STS_SIZE`): `rdata` = 0, `rresp` = 2'b10 (SLVERR).
- In-range read: `rresp` = 2'b00.
- Read pipeline: output register (`rdata`/`rresp`/`rvalid`) plus a one-entry skid (address + valid).
  - Read accepted when `arvalid & arready`.
  - If the output register is free (`~rvalid | rready`), the accepted address loads the output next edge.
  - Otherwise it goes to the skid, and `arready` is 0 from the next cycle.
  - When the skid is full and `rready` is seen with `rvalid`, the skid loads the output next edge and `arready` returns to 1 at the same edge.
- Data is sampled from `sts_data`/shadow on the edge the output register loads, not at address acceptance.
- Snapshot (see Configuration):
  - The edge that loads an in-range idx=0 read also copies all of `sts_data` into the shadow.
  - Word 0 returns live `sts_data` word 0 at that edge.
  - Reads of idx 1..`STS_SIZE`-1 return shadow words.
  - An out-of-range read never updates the shadow.
- Write channel:
  - AW and W are each accepted independently and latched; `awready`/`wready` each drop after their beat is latched.
  - When both are latched (same or different cycles), `bvalid` = 1 next edge with `bresp` = 2'b10.
  - On the `bvalid & bready` edge, both latches clear and `awready`/`wready` return to 1.
  - Write data is discarded; no state changes.

## Timing
- Reset values:
  - `arready` = 1, `rvalid` = 0, `rdata` = 0, `rresp` = 0, skid empty.
  - `awready` = 1, `wready` = 1, `bvalid` = 0, `bresp` = 0, shadow = 0.
- Read latency: `rvalid` is asserted 1 cycle after acceptance when not stalled.
- Throughput: one read per cycle with `rready` held 1.
- Back-pressure: at most 2 reads are held (output + skid). No read is lost or reordered.
- `rdata`/`rresp` are stable while `rvalid & ~rready`.
- Write: `bvalid` 1 cycle after the later of AW/W acceptance. Back-to-back writes: 1 per 2 cycles minimum.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously); the pending response is dropped.

## Configuration
- `AXI_STS_SNAPSHOT_EN` defined: shadow register present; snapshot behaviour as above.
- Not defined: no shadow flops; every word, including idx 0, reads live `sts_data` at the output-load edge. All other behaviour is identical.

## Test plan
- Reset, then read idx 0..3 with `rready`=1 and `STS_DATA_WIDTH`=128, `sts_data`=128'h4444_4444_3333_3333_2222_2222_1111_1111 -> rdata 1111_1111, 2222_2222, 3333_3333, 4444_4444 on consecutive cycles, `rresp`=0, `arready` never drops.
- Snapshot: read idx 0, then change `sts_data` word 1 to DEAD_BEEF, then read idx 1 -> old 2222_2222 with macro, DEAD_BEEF without.
- Back-pressure: 3 reads offered back-to-back with `rready`=0 -> `arready`=0 after the 2nd acceptance. Raise `rready` -> 3 responses in order, none lost.
- Out-of-range: read address 0x0010 with `STS_SIZE`=4 -> `rdata`=0, `rresp`=2'b10; the following idx 1 read still returns shadow data unchanged.
- Write: AW at cycle 0, W at cycle 3, `bready`=0 until cycle 6 -> `bvalid` from cycle 4 to 6 with `bresp`=2'b10; `awready`/`wready` = 1 again after the cycle-6 handshake; read data unaffected.
- Assert `aresetn`=0 while `rvalid`=1 and the skid is full -> `rvalid`=0 and `arready`=1 immediately; the next read after release behaves normally.
